// File: rtl/i2s_dma_channel_arbiter.sv
// Round-robin arbiter that shares one SDMA channel among NUM_REQ requesters.
// It drives the channel request/clear handshake, counts pops and reports per-requester done or start timeout.
module i2s_dma_channel_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 9,
  parameter int TMO_W   = 16
) (
  input  logic                     WBs_CLK_i,
  input  logic                     WBs_RST_n_i,
  input  logic                     Arb_EN_i,
  input  logic [NUM_REQ-1:0]       Req_i,
  input  logic [NUM_REQ*CNT_W-1:0] Xfr_Cnt_i,
  input  logic [NUM_REQ-1:0]       Pop_i,
  input  logic [TMO_W-1:0]         Tmo_Limit_i,
  input  logic                     Tmo_Clr_i,
  input  logic                     DMA_Active_i,
  output logic                     DMA_REQ_o,
  output logic                     DMA_Clr_o,
  output logic [NUM_REQ-1:0]       Gnt_o,
  output logic [NUM_REQ-1:0]       Done_o,
  output logic                     Busy_o,
  output logic [1:0]               Cur_Sel_o,
  output logic [CNT_W-1:0]         Cntr_o,
  output logic                     Tmo_Flag_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_XFR, ST_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_ptr, w_ptr_next;
  logic [1:0]         r_sel, w_sel_next;
  logic               r_dma_req, w_dma_req_next;
  logic               r_dma_clr, w_dma_clr_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic [NUM_REQ-1:0] r_done, w_done_next;
  logic               r_busy, w_busy_next;
  logic [CNT_W-1:0]   r_cntr, w_cntr_next;
  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_next;
  logic               r_tmo_flag, w_tmo_flag_next;
  logic               r_act_meta, w_act_meta_next;
  logic               r_act_sync, w_act_sync_next;
  logic               w_tmo_set;

  logic [3:0]         w_req4;
  logic [3:0]         w_pop4;
  logic [CNT_W-1:0]   w_xfr_cnt [4];
  logic [2:0]         w_rot_sum [NUM_REQ];
  logic [1:0]         w_rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_rot_req;
  logic [1:0]         w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [NUM_REQ-1:0] w_sel_oh;
  logic               w_any_req;
  logic               w_tmo_hit;

  // Pad per-requester inputs to four entries so a 2-bit select never indexes out of range.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_used
        assign w_req4[gi]    = Req_i[gi];
        assign w_pop4[gi]    = Pop_i[gi];
        assign w_xfr_cnt[gi] = Xfr_Cnt_i[gi*CNT_W +: CNT_W];
      end else begin : g_unused
        assign w_req4[gi]    = 1'b0;
        assign w_pop4[gi]    = 1'b0;
        assign w_xfr_cnt[gi] = '0;
      end
    end

    // Requester indices in scan order: ptr, ptr+1, ... wrapping at NUM_REQ.
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign w_rot_sum[gi] = {1'b0, r_ptr} + 3'(gi);
      assign w_rot_idx[gi] = (w_rot_sum[gi] >= 3'(NUM_REQ)) ?
                             2'(w_rot_sum[gi] - 3'(NUM_REQ)) : w_rot_sum[gi][1:0];
      assign w_rot_req[gi] = w_req4[w_rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    w_pick = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot_req[i]) w_pick = w_rot_idx[i];
    end
  end

  assign w_pick_oh = NUM_REQ'(1) << w_pick;
  assign w_sel_oh  = NUM_REQ'(1) << r_sel;
  assign w_any_req = |Req_i;
  assign w_tmo_hit = (Tmo_Limit_i != '0) && (r_tmo_cnt == Tmo_Limit_i - TMO_W'(1));

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_sel_next      = r_sel;
    w_dma_req_next  = r_dma_req;
    w_dma_clr_next  = 1'b0;
    w_gnt_next      = r_gnt;
    w_done_next     = '0;
    w_busy_next     = r_busy;
    w_cntr_next     = r_cntr;
    w_tmo_cnt_next  = r_tmo_cnt;
    w_tmo_set       = 1'b0;
    w_act_meta_next = DMA_Active_i;
    w_act_sync_next = r_act_meta;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_sel_next     = w_pick;
          w_gnt_next     = w_pick_oh;
          w_dma_req_next = 1'b1;
          w_busy_next    = 1'b1;
          w_tmo_cnt_next = '0;
          w_state_next   = ST_START;
        end
      end
      ST_START: begin
        if (!w_req4[r_sel]) begin
          w_dma_req_next = 1'b0;
          w_gnt_next     = '0;
          w_busy_next    = 1'b0;
          w_state_next   = ST_IDLE;
        end else if (r_act_sync) begin
          w_dma_req_next = 1'b0;
          w_dma_clr_next = 1'b1;
          w_cntr_next    = '0;
          w_state_next   = ST_XFR;
        end else if (w_tmo_hit) begin
          w_dma_req_next = 1'b0;
          w_tmo_set      = 1'b1;
          w_state_next   = ST_DONE;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
        end
      end
      ST_XFR: begin
        // The match uses the registered count, so a pop on the matching cycle is dropped.
        if (r_cntr == w_xfr_cnt[r_sel]) begin
          w_done_next  = w_sel_oh;
          w_state_next = ST_DONE;
        end else if (w_pop4[r_sel]) begin
          w_cntr_next = r_cntr + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_gnt_next   = '0;
        w_busy_next  = 1'b0;
        w_ptr_next   = (r_sel == 2'(NUM_REQ - 1)) ? 2'd0 : r_sel + 2'd1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (!Arb_EN_i) begin
      w_state_next    = ST_IDLE;
      w_ptr_next      = '0;
      w_sel_next      = '0;
      w_dma_req_next  = 1'b0;
      w_dma_clr_next  = 1'b0;
      w_gnt_next      = '0;
      w_done_next     = '0;
      w_busy_next     = 1'b0;
      w_cntr_next     = '0;
      w_tmo_cnt_next  = '0;
      w_tmo_set       = 1'b0;
      w_act_meta_next = 1'b0;
      w_act_sync_next = 1'b0;
    end

    // Sticky flag survives Arb_EN_i=0; a new timeout beats a simultaneous clear.
    if (w_tmo_set)      w_tmo_flag_next = 1'b1;
    else if (Tmo_Clr_i) w_tmo_flag_next = 1'b0;
    else                w_tmo_flag_next = r_tmo_flag;
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_dma_req  <= 1'b0;
      r_dma_clr  <= 1'b0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_cntr     <= '0;
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
      r_act_meta <= 1'b0;
      r_act_sync <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_sel      <= w_sel_next;
      r_dma_req  <= w_dma_req_next;
      r_dma_clr  <= w_dma_clr_next;
      r_gnt      <= w_gnt_next;
      r_done     <= w_done_next;
      r_busy     <= w_busy_next;
      r_cntr     <= w_cntr_next;
      r_tmo_cnt  <= w_tmo_cnt_next;
      r_tmo_flag <= w_tmo_flag_next;
      r_act_meta <= w_act_meta_next;
      r_act_sync <= w_act_sync_next;
    end
  end

  assign DMA_REQ_o  = r_dma_req;
  assign DMA_Clr_o  = r_dma_clr;
  assign Gnt_o      = r_gnt;
  assign Done_o     = r_done;
  assign Busy_o     = r_busy;
  assign Cur_Sel_o  = r_sel;
  assign Cntr_o     = r_cntr;
  assign Tmo_Flag_o = r_tmo_flag;

endmodule

// File: tb/tb_i2s_dma_channel_arbiter.sv
// Randomized scoreboard bench for i2s_dma_channel_arbiter: a transaction-level round-robin
// model queues expected events and a negedge monitor matches what the DUT presents.
module tb_i2s_dma_channel_arbiter;
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 9;
  localparam int TMO_W   = 16;

  localparam int EV_GNT  = 0;
  localparam int EV_CLR  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_TMO  = 3;
  localparam int EV_IDLE = 4;

  localparam int M_NORMAL   = 0;
  localparam int M_TIMEOUT  = 1;
  localparam int M_WITHDRAW = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     en = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*CNT_W-1:0] xfr_cnt = '0;
  logic [NUM_REQ-1:0]       pop = '0;
  logic [TMO_W-1:0]         tmo_limit = '0;
  logic                     tmo_clr = 1'b0;
  logic                     dma_active = 1'b0;
  logic                     dma_req, dma_clr, busy, tmo_flag;
  logic [NUM_REQ-1:0]       gnt, done;
  logic [1:0]               cur_sel;
  logic [CNT_W-1:0]         cntr;

  always #5 clk = ~clk;

  i2s_dma_channel_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .WBs_CLK_i   (clk),
    .WBs_RST_n_i (rst_n),
    .Arb_EN_i    (en),
    .Req_i       (req),
    .Xfr_Cnt_i   (xfr_cnt),
    .Pop_i       (pop),
    .Tmo_Limit_i (tmo_limit),
    .Tmo_Clr_i   (tmo_clr),
    .DMA_Active_i(dma_active),
    .DMA_REQ_o   (dma_req),
    .DMA_Clr_o   (dma_clr),
    .Gnt_o       (gnt),
    .Done_o      (done),
    .Busy_o      (busy),
    .Cur_Sel_o   (cur_sel),
    .Cntr_o      (cntr),
    .Tmo_Flag_o  (tmo_flag)
  );

  typedef struct {
    int kind;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  ref_ptr = 0;
  int  txn_no = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Reference round-robin: first requesting index scanning upward from the pointer.
  function automatic int ref_pick(input int mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = (ref_ptr + i) % NUM_REQ;
      if (((mask >> c) & 1) != 0) return c;
    end
    return 0;
  endfunction

  function automatic void push_ev(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic bit cond(input int what);
    case (what)
      EV_GNT:  return gnt != '0;
      EV_CLR:  return dma_clr;
      EV_DONE: return done != '0;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int what, input string name);
    int n;
    n = 0;
    while (!cond(what) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cond(what)) begin
      checks++;
      errors++;
      $display("FAIL wait %s: not seen, expected within 100 cycles", name);
      finish_run();
    end
  endtask

  task automatic observe(input int kind, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: got kind %0d data 0x%0h, expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event kind", kind, e.kind);
      if (kind == e.kind) check($sformatf("event %0d data", kind), data, e.data);
    end
  endtask

  // Monitor: turns output changes into events and matches them against the queue.
  initial begin
    logic [NUM_REQ-1:0] prev_gnt;
    logic               prev_busy;
    logic               prev_flag;
    prev_gnt  = '0;
    prev_busy = 1'b0;
    prev_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_gnt == '0 && gnt != '0)
          observe(EV_GNT, (int'(dma_req) << 8) | (int'(cur_sel) << 4) | int'(gnt));
        if (dma_clr)
          observe(EV_CLR, (int'(busy) << 12) | (int'(dma_req) << 8) | int'(gnt));
        if (done != '0)
          observe(EV_DONE, (int'(cntr) << 8) | int'(done));
        if (tmo_flag && !prev_flag)
          observe(EV_TMO, (int'(dma_req) << 8) | (int'(done) << 4) | int'(gnt));
        if (prev_busy && !busy)
          observe(EV_IDLE, (int'(done) << 8) | (int'(gnt) << 4) | int'(cur_sel));
      end
      prev_gnt  = gnt;
      prev_busy = busy;
      prev_flag = tmo_flag;
    end
  end

  // One transaction, entered at a negedge with the DUT idle.
  // clr_mode: 0 pulse Tmo_Clr_i after a timeout, 1 hold it throughout, 2 leave the flag set.
  task automatic run_txn(input int mask, input int mode, input int clr_mode, input int force_cnt);
    int k, lim, n, cyc;
    int cnts[NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) begin
      cnts[i] = (force_cnt >= 0) ? force_cnt : $urandom_range(0, 6);
      xfr_cnt[i*CNT_W +: CNT_W] = CNT_W'(cnts[i]);
    end
    k = ref_pick(mask);
    push_ev(EV_GNT, (1 << 8) | (k << 4) | (1 << k));
    if (mode == M_NORMAL) begin
      lim = ($urandom_range(0, 1) == 0) ? 0 : 20;
      push_ev(EV_CLR, (1 << 12) | (1 << k));
      push_ev(EV_DONE, (cnts[k] << 8) | (1 << k));
      push_ev(EV_IDLE, k);
      ref_ptr = (k + 1) % NUM_REQ;
    end else if (mode == M_TIMEOUT) begin
      lim = $urandom_range(1, 10);
      push_ev(EV_TMO, 1 << k);
      push_ev(EV_IDLE, k);
      ref_ptr = (k + 1) % NUM_REQ;
    end else begin
      lim = 0;
      push_ev(EV_IDLE, k);
    end
    $display("txn %0d: mode=%0d req=%b sel=%0d len=%0d tmo=%0d", txn_no, mode, mask[NUM_REQ-1:0], k, cnts[k], lim);
    txn_no++;
    tmo_limit  = TMO_W'(lim);
    tmo_clr    = (mode == M_TIMEOUT && clr_mode == 1);
    dma_active = 1'b0;
    req        = NUM_REQ'(mask);
    @(negedge clk);
    check("request latency", int'(dma_req), 1);

    if (mode == M_NORMAL) begin
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
      dma_active = 1'b1;
      wait_for(EV_CLR, "clear pulse");
      dma_active = 1'b0;
      for (int p = 0; p < cnts[k]; ) begin
        pop = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
        pop[k] = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          pop[k] = 1'b1;
          p++;
        end
        @(negedge clk);
      end
      pop = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      @(negedge clk);
      pop = '0;
      check("done after last pop", int'(done), 1 << k);
      wait_for(EV_IDLE, "idle after done");
    end else if (mode == M_TIMEOUT) begin
      cyc = 0;
      while (dma_req && cyc < 40) begin
        cyc++;
        @(negedge clk);
      end
      check("timeout start cycles", cyc, lim);
      req = '0;
      wait_for(EV_IDLE, "idle after timeout");
      if (clr_mode == 0) begin
        tmo_clr = 1'b1;
        @(negedge clk);
        tmo_clr = 1'b0;
        check("flag after clear", int'(tmo_flag), 0);
      end else if (clr_mode == 1) begin
        check("flag with clear held", int'(tmo_flag), 0);
        tmo_clr = 1'b0;
      end
    end else begin
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
      req = NUM_REQ'(mask) & ~(NUM_REQ'(1) << k);
      wait_for(EV_IDLE, "idle after withdraw");
    end
  endtask

  // Bring a transaction to XFR with `npop` pops counted; returns the granted index.
  task automatic start_xfr(input int mask, input int npop, output int k);
    k = ref_pick(mask);
    xfr_cnt = '0;
    xfr_cnt[k*CNT_W +: CNT_W] = CNT_W'(9);
    tmo_limit = '0;
    push_ev(EV_GNT, (1 << 8) | (k << 4) | (1 << k));
    push_ev(EV_CLR, (1 << 12) | (1 << k));
    req = NUM_REQ'(mask);
    @(negedge clk);
    dma_active = 1'b1;
    wait_for(EV_CLR, "clear pulse");
    dma_active = 1'b0;
    repeat (npop) begin
      pop = NUM_REQ'(1) << k;
      @(negedge clk);
    end
    pop = '0;
    @(negedge clk);
    check("count before abort", int'(cntr), npop);
  endtask

  initial begin
    int mask, r, mode, k;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", int'({dma_req, dma_clr, gnt, done, busy, cur_sel, cntr}), 0);
    check("reset flag", int'(tmo_flag), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    check("idle outputs", int'({dma_req, dma_clr, gnt, done, busy, cur_sel, cntr}), 0);
    mon_en = 1'b1;

    run_txn(1, M_NORMAL, 0, 4);
    repeat (4) run_txn(3, M_NORMAL, 0, 2);
    run_txn(3, M_NORMAL, 0, 0);
    run_txn(1, M_TIMEOUT, 0, -1);
    run_txn(3, M_WITHDRAW, 0, -1);
    run_txn(3, M_NORMAL, 0, -1);

    for (int t = 0; t < 60; t++) begin
      mask = $urandom_range(1, (1 << NUM_REQ) - 1);
      r    = $urandom_range(0, 9);
      mode = (r < 6) ? M_NORMAL : (r < 8) ? M_TIMEOUT : M_WITHDRAW;
      run_txn(mask, mode, $urandom_range(0, 1), -1);
    end
    req = '0;

    // Abort mid-transfer with the sticky flag set: flag must survive Arb_EN_i=0.
    run_txn(1, M_TIMEOUT, 2, -1);
    check("flag kept set", int'(tmo_flag), 1);
    start_xfr(2, 2, k);
    check("scoreboard before abort", exp_q.size(), 0);
    mon_en = 1'b0;
    en     = 1'b0;
    @(negedge clk);
    check("abort outputs", int'({dma_req, dma_clr, gnt, done, busy, cur_sel, cntr}), 0);
    check("abort keeps flag", int'(tmo_flag), 1);
    en      = 1'b1;
    req     = '0;
    ref_ptr = 0;
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    check("flag clear after abort", int'(tmo_flag), 0);
    mon_en = 1'b1;
    run_txn(3, M_NORMAL, 0, -1);

    // Asynchronous reset mid-transfer with the flag set.
    run_txn(1, M_TIMEOUT, 2, -1);
    start_xfr(2, 3, k);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", int'({dma_req, dma_clr, gnt, done, busy, cur_sel, cntr}), 0);
    check("async reset flag", int'(tmo_flag), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    req     = '0;
    ref_ptr = 0;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    run_txn(3, M_NORMAL, 0, -1);
    run_txn(3, M_NORMAL, 0, -1);

    req = '0;
    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    finish_run();
  end

endmodule
